ie_branch_unit: RTL and testbench

- Branch/jump resolver for the CPU instruction-execution (IE) stage; the IE issues a branch code and this block answers.
- IE supplies a branch opcode (BCC..BVS, JMP), the status register, the PC and the operand; the block returns taken/not-taken, the new PC and the 6502 extra-cycle penalty.
- JMP indirect fetches its 16-bit target through a byte-wide memory read handshake.

---
 rtl/ie_branch_unit.sv | 180 ++++++++++++++++++
 tb/tb_ie_branch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ie_branch_unit.sv
// IE-stage branch/jump resolver: conditional branches, JMP abs, and JMP indirect via byte-wide reads.
// Define IE_CMOS_JMP_FIX_EN for 65C02 carry into the pointer high byte on the second indirect read.
module ie_branch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        br_op,
  input  logic              jmp_ind,
  input  logic [ADDR_W-1:0] operand,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [7:0]        status,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic [ADDR_W-1:0] new_pc,
  output logic [1:0]        extra_cycles,
  output logic              illegal
);

  localparam logic [7:0] OP_BCC = 8'h04, OP_BCS = 8'h05, OP_BEQ = 8'h06, OP_BMI = 8'h07;
  localparam logic [7:0] OP_BNE = 8'h08, OP_BPL = 8'h09, OP_BVC = 8'h0A, OP_BVS = 8'h0B;
  localparam logic [7:0] OP_JMP = 8'h1C;

  typedef enum logic [2:0] {IDLE, EVAL, PTR_LO, PTR_HI, FINISH} state_t;

  state_t              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic                ind_q, ind_d;
  logic [ADDR_W-1:0]   opr_q, opr_d, pc_q, pc_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                gap_q, gap_d;
  logic                taken_q, taken_d, illegal_q, illegal_d, done_q, done_d;
  logic [ADDR_W-1:0]   new_pc_q, new_pc_d;
  logic [1:0]          extra_q, extra_d;

  logic                is_branch, cond;
  logic [ADDR_W-1:0]   rel_tgt, hi_addr;
  logic                unused_status;

  assign unused_status = ^status[5:2];

  // flags_q packs {N, V, Z, C}
  always_comb begin
    is_branch = 1'b1;
    cond      = 1'b0;
    case (op_q)
      OP_BCC:  cond = ~flags_q[0];
      OP_BCS:  cond =  flags_q[0];
      OP_BEQ:  cond =  flags_q[1];
      OP_BMI:  cond =  flags_q[3];
      OP_BNE:  cond = ~flags_q[1];
      OP_BPL:  cond = ~flags_q[3];
      OP_BVC:  cond = ~flags_q[2];
      OP_BVS:  cond =  flags_q[2];
      default: is_branch = 1'b0;
    endcase
  end

  assign rel_tgt = pc_q + {{(ADDR_W-8){opr_q[7]}}, opr_q[7:0]};

`ifdef IE_CMOS_JMP_FIX_EN
  assign hi_addr = opr_q + ADDR_W'(1);
`else
  // NMOS quirk: the pointer's low byte wraps without carrying into the page
  assign hi_addr = {opr_q[ADDR_W-1:8], opr_q[7:0] + 8'd1};
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ind_d     = ind_q;
    opr_d     = opr_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    lo_d      = lo_q;
    gap_d     = 1'b0;
    taken_d   = taken_q;
    new_pc_d  = new_pc_q;
    extra_d   = extra_q;
    illegal_d = illegal_q;
    done_d    = (state_q == FINISH);
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          op_d    = br_op;
          ind_d   = jmp_ind;
          opr_d   = operand;
          pc_d    = pc_in;
          flags_d = {status[7], status[6], status[1], status[0]};
          state_d = EVAL;
        end
      end
      EVAL: begin
        illegal_d = 1'b0;
        extra_d   = 2'd0;
        state_d   = FINISH;
        if (op_q == OP_JMP) begin
          taken_d = ~ind_q;
          if (ind_q) state_d = PTR_LO;
          else       new_pc_d = opr_q;
        end else if (is_branch) begin
          taken_d  = cond;
          new_pc_d = cond ? rel_tgt : pc_q;
          if (cond) extra_d = (rel_tgt[ADDR_W-1:8] != pc_q[ADDR_W-1:8]) ? 2'd2 : 2'd1;
        end else begin
          illegal_d = 1'b1;
          taken_d   = 1'b0;
          new_pc_d  = pc_q;
        end
      end
      PTR_LO: begin
        if (mem_rd_valid) begin
          lo_d    = mem_rd_data;
          gap_d   = 1'b1;
          state_d = PTR_HI;
        end
      end
      PTR_HI: begin
        if (!gap_q && mem_rd_valid) begin
          new_pc_d = ADDR_W'({mem_rd_data, lo_q});
          taken_d  = 1'b1;
          state_d  = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      ind_q     <= 1'b0;
      opr_q     <= '0;
      pc_q      <= '0;
      flags_q   <= '0;
      lo_q      <= '0;
      gap_q     <= 1'b0;
      taken_q   <= 1'b0;
      new_pc_q  <= '0;
      extra_q   <= 2'd0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ind_q     <= ind_d;
      opr_q     <= opr_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      lo_q      <= lo_d;
      gap_q     <= gap_d;
      taken_q   <= taken_d;
      new_pc_q  <= new_pc_d;
      extra_q   <= extra_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  // done is registered, so busy stays up through the done cycle to block a premature start
  assign mem_rd_req   = (state_q == PTR_LO) || ((state_q == PTR_HI) && !gap_q);
  assign mem_addr     = (state_q == PTR_LO) ? opr_q : (state_q == PTR_HI) ? hi_addr : '0;
  assign busy         = (state_q != IDLE) || done_q;
  assign done         = done_q;
  assign taken        = taken_q;
  assign new_pc       = new_pc_q;
  assign extra_cycles = extra_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_ie_branch_unit.sv
// Self-checking bench for ie_branch_unit: directed vectors, behavioural model, 3-cycle memory responder.
module tb_ie_branch_unit;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  br_op;
  logic        jmp_ind;
  logic [15:0] operand;
  logic [15:0] pc_in;
  logic [7:0]  status;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_rd_valid;
  logic        busy;
  logic        done;
  logic        taken;
  logic [15:0] new_pc;
  logic [1:0]  extra_cycles;
  logic        illegal;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  logic        exp_taken;
  logic [15:0] exp_pc;
  logic [1:0]  exp_extra;
  logic        exp_ill;
  bit          expect_done = 1'b0;
  int          done_seen = 0;
  int          lat = 0;
  logic [15:0] req_addr = '0;

  always #5 clk = ~clk;

  ie_branch_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .br_op(br_op), .jmp_ind(jmp_ind),
    .operand(operand), .pc_in(pc_in), .status(status), .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .busy(busy), .done(done), .taken(taken), .new_pc(new_pc),
    .extra_cycles(extra_cycles), .illegal(illegal)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour written from the 6502 branch rules with plain integer arithmetic
  function automatic void model(input logic [7:0] op, input logic ind, input logic [15:0] opr,
                                input logic [15:0] pc, input logic [7:0] st,
                                output logic t, output logic [15:0] np,
                                output logic [1:0] ex, output logic il);
    bit c, z, v, n, cond, isb;
    int off, tgt, hi;
    c = st[0]; z = st[1]; v = st[6]; n = st[7];
    cond = 1'b0; isb = 1'b1;
    t = 1'b0; np = pc; ex = 2'd0; il = 1'b0;
    case (op)
      8'h04: cond = !c;
      8'h05: cond = c;
      8'h06: cond = z;
      8'h07: cond = n;
      8'h08: cond = !z;
      8'h09: cond = !n;
      8'h0A: cond = !v;
      8'h0B: cond = v;
      8'h1C: begin
        isb = 1'b0;
        t = 1'b1;
        if (!ind) np = opr;
        else begin
`ifdef IE_CMOS_JMP_FIX_EN
          hi = (int'(opr) + 1) % 65536;
`else
          hi = (int'(opr) / 256) * 256 + ((int'(opr) % 256) + 1) % 256;
`endif
          np = {mem[hi], mem[int'(opr)]};
        end
      end
      default: begin
        isb = 1'b0;
        il = 1'b1;
      end
    endcase
    if (isb && cond) begin
      off = opr[7] ? int'(opr[7:0]) - 256 : int'(opr[7:0]);
      tgt = (int'(pc) + off + 65536) % 65536;
      np  = 16'(tgt);
      t   = 1'b1;
      ex  = ((tgt / 256) != (int'(pc) / 256)) ? 2'd2 : 2'd1;
    end
  endfunction

  // Memory responder: fixed latency, checks the address is held while the request is up
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (reset_n && mem_rd_req) begin
        if (lat == 0) req_addr = mem_addr;
        else checkOutput("addr_stable", mem_addr, req_addr);
        lat++;
        if (lat == MEM_LAT) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem[int'(mem_addr)];
          lat = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Compare process: every done pulse is checked against the model's prediction
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_seen++;
      if (!expect_done) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got 1 expected 0");
      end else begin
        checkOutput("model_taken", 16'(taken), 16'(exp_taken));
        checkOutput("model_new_pc", new_pc, exp_pc);
        checkOutput("model_extra", 16'(extra_cycles), 16'(exp_extra));
        checkOutput("model_illegal", 16'(illegal), 16'(exp_ill));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] op, input logic ind, input logic [15:0] opr,
                               input logic [15:0] pc, input logic [7:0] st,
                               input logic lt, input logic [15:0] lp, input logic [1:0] le,
                               input logic li, input bit check_lat, input bit poke);
    int cyc;
    @(negedge clk);
    br_op = op; jmp_ind = ind; operand = opr; pc_in = pc; status = st; start = 1'b1;
    model(op, ind, opr, pc, st, exp_taken, exp_pc, exp_extra, exp_ill);
    expect_done = 1'b1;
    done_seen = 0;
    @(negedge clk);
    start = 1'b0;
    br_op = 8'hFF; jmp_ind = ~ind; operand = ~opr; pc_in = ~pc; status = ~st;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (poke) begin
        start = (cyc == 3);
        br_op = 8'h06;
      end
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done expected done within 200 cycles");
    end
    if (check_lat) checkOutput("latency", 16'(cyc), 16'd2);
    checkOutput("lit_taken", 16'(taken), 16'(lt));
    checkOutput("lit_new_pc", new_pc, lp);
    checkOutput("lit_extra", 16'(extra_cycles), 16'(le));
    checkOutput("lit_illegal", 16'(illegal), 16'(li));
    repeat (3) @(negedge clk);
    checkOutput("done_pulses", 16'(done_seen), 16'd1);
    checkOutput("busy_idle", 16'(busy), 16'd0);
    checkOutput("hold_new_pc", new_pc, lp);
    expect_done = 1'b0;
  endtask

  task automatic resetDuringPtrHi();
    int cyc;
    @(negedge clk);
    br_op = 8'h1C; jmp_ind = 1'b1; operand = 16'h02FF; pc_in = 16'h9000; status = 8'h00;
    start = 1'b1;
    expect_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!mem_rd_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("first_read_valid", 16'(mem_rd_valid), 16'd1);
    repeat (2) @(negedge clk);
    checkOutput("ptr_hi_req", 16'(mem_rd_req), 16'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_req_drop", 16'(mem_rd_req), 16'd0);
    checkOutput("rst_busy_drop", 16'(busy), 16'd0);
    checkOutput("rst_done_low", 16'(done), 16'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_done", 16'(done), 16'd0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_done", 16'(done), 16'd0);
    checkOutput("post_rst_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h02FF] = 8'h34;
    mem[16'h0200] = 8'h12;
    mem[16'h0300] = 8'h56;
    reset_n = 1'b0; start = 1'b0; br_op = '0; jmp_ind = 1'b0;
    operand = '0; pc_in = '0; status = '0;
    #1;
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_req", 16'(mem_rd_req), 16'd0);
    checkOutput("rst_addr", mem_addr, 16'h0000);
    checkOutput("rst_taken", 16'(taken), 16'd0);
    checkOutput("rst_new_pc", new_pc, 16'h0000);
    checkOutput("rst_extra", 16'(extra_cycles), 16'd0);
    checkOutput("rst_illegal", 16'(illegal), 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(8'h06, 1'b0, 16'h0005, 16'h8010, 8'h02, 1'b1, 16'h8015, 2'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h08, 1'b0, 16'h0005, 16'h8010, 8'h02, 1'b0, 16'h8010, 2'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h0B, 1'b0, 16'h0005, 16'h8010, 8'h40, 1'b1, 16'h8015, 2'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h04, 1'b0, 16'h0020, 16'h80F0, 8'h00, 1'b1, 16'h8110, 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h09, 1'b0, 16'h00F0, 16'h8005, 8'h00, 1'b1, 16'h7FF5, 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h04, 1'b0, 16'h0020, 16'hFFF0, 8'h00, 1'b1, 16'h0010, 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h07, 1'b0, 16'h0080, 16'h4000, 8'h80, 1'b1, 16'h3F80, 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h05, 1'b0, 16'h007F, 16'h4000, 8'h01, 1'b1, 16'h407F, 2'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h0A, 1'b0, 16'h0010, 16'h4000, 8'h40, 1'b0, 16'h4000, 2'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h10, 1'b0, 16'h0010, 16'h1234, 8'hFF, 1'b0, 16'h1234, 2'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h1C, 1'b0, 16'hC000, 16'h8000, 8'h00, 1'b1, 16'hC000, 2'd0, 1'b0, 1'b1, 1'b0);
`ifdef IE_CMOS_JMP_FIX_EN
    applyStimulus(8'h1C, 1'b1, 16'h02FF, 16'h8000, 8'h00, 1'b1, 16'h5634, 2'd0, 1'b0, 1'b0, 1'b1);
`else
    applyStimulus(8'h1C, 1'b1, 16'h02FF, 16'h8000, 8'h00, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b1);
`endif
    resetDuringPtrHi();
    applyStimulus(8'h06, 1'b0, 16'h0005, 16'h8010, 8'h02, 1'b1, 16'h8015, 2'd1, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
